vpu_result_wb: RTL and testbench

Result write-back stage directly downstream of the VPU execution unit. It pairs each issued operation's destination address with the result the execution unit later produces, buffers address/data pairs, and drives them to the vector register file over a valid/ready write port. Completion is detected from the execution unit's level `done` signal, which idles high, by edge detection.

---
 rtl/vpu_result_wb_pkg.sv | 20 ++
 rtl/vpu_result_wb_fifo.sv | 50 +++++
 rtl/vpu_result_wb.sv | 101 ++++++++++
 tb/tb_vpu_result_wb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_result_wb_pkg.sv
// Shared constants and entry type for the VPU result write-back stage.
// The optional VPU_WB_PARITY_EN macro adds a parity bit to each result entry.
package VPU_PKG;

   localparam int unsigned DWIDTH_PER_EXEC = 32;
   localparam int unsigned WB_ADDR_WIDTH   = 8;
   localparam int unsigned WB_DEPTH        = 4;

   localparam int unsigned WB_ERR_OVF    = 0;
   localparam int unsigned WB_ERR_ORPHAN = 1;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0]   addr;
      logic [DWIDTH_PER_EXEC-1:0] data;
`ifdef VPU_WB_PARITY_EN
      logic                       parity;
`endif
   } vpu_wb_entry_t;

endpackage

// File: rtl/vpu_result_wb_fifo.sv
// Generic synchronous FIFO with registered storage, zero head when empty, full/empty flags.
// A pop on the same cycle frees room for a push into a full FIFO.
module vpu_wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/vpu_result_wb.sv
// Pairs issued destination tags with execution results on rising done edges and drives writes.
// Defining VPU_WB_PARITY_EN adds wr_parity_o, stored with each result at push time.
module vpu_result_wb
   import VPU_PKG::*;
#(
   parameter int unsigned DWIDTH     = DWIDTH_PER_EXEC,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int unsigned DEPTH      = WB_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid_i,
   input  logic [ADDR_WIDTH-1:0] issue_dst_addr_i,
   output logic                  issue_ready_o,
   input  logic                  exec_done_i,
   input  logic [DWIDTH-1:0]     exec_dout_i,
   output logic                  wr_valid_o,
   input  logic                  wr_ready_i,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DWIDTH-1:0]     wr_data_o,
   output logic                  busy_o,
`ifdef VPU_WB_PARITY_EN
   output logic                  wr_parity_o,
`endif
   output logic [1:0]            err_o
);

`ifdef VPU_WB_PARITY_EN
   localparam int unsigned PW = 1;
`else
   localparam int unsigned PW = 0;
`endif
   localparam int unsigned RW = ADDR_WIDTH + DWIDTH + PW;

   logic                  done_q, done_rise;
   logic [1:0]            err_q;
   logic                  tag_push, tag_pop, tag_full, tag_empty;
   logic [ADDR_WIDTH-1:0] tag_head;
   logic                  res_push, res_pop, res_full, res_empty;
   logic [RW-1:0]         res_din, res_dout;

   assign done_rise = exec_done_i & ~done_q;
   assign tag_push  = issue_valid_i && issue_ready_o;
   assign tag_pop   = done_rise && !tag_empty;
   assign res_push  = tag_pop;
   assign res_pop   = wr_valid_o && wr_ready_i;

`ifdef VPU_WB_PARITY_EN
   assign res_din = {tag_head, exec_dout_i, ^exec_dout_i};
   assign {wr_addr_o, wr_data_o, wr_parity_o} = res_dout;
`else
   assign res_din = {tag_head, exec_dout_i};
   assign {wr_addr_o, wr_data_o} = res_dout;
`endif

   assign issue_ready_o = !tag_full;
   assign wr_valid_o    = !res_empty;
   assign busy_o        = !tag_empty || !res_empty;
   assign err_o         = err_q;

   vpu_wb_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .din   (issue_dst_addr_i),
      .pop   (tag_pop),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );

   vpu_wb_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_push),
      .din   (res_din),
      .pop   (res_pop),
      .dout  (res_dout),
      .full  (res_full),
      .empty (res_empty)
   );

   // done_q resets high so an idle-high done level does not look like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b1;
         err_q  <= 2'b00;
      end else begin
         done_q <= exec_done_i;
         if (done_rise && tag_empty)             err_q[WB_ERR_ORPHAN] <= 1'b1;
         if (res_push && res_full && !res_pop)   err_q[WB_ERR_OVF]    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vpu_result_wb.sv
// Randomized and directed bench for vpu_result_wb against a queue-based reference model.
// Define VPU_WB_PARITY_EN for both RTL and bench to cover the parity output.
module tb_vpu_result_wb;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [7:0]  issue_addr = '0;
   logic        issue_ready;
   logic        exec_done = 1'b1;
   logic [31:0] exec_dout = '0;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic [1:0]  err;
`ifdef VPU_WB_PARITY_EN
   logic        wr_parity;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_tag[$];
   logic [7:0]  m_addr[$];
   logic [31:0] m_data[$];
   logic        m_done_q = 1'b1;
   logic [1:0]  m_err = 2'b00;

   always #5 clk = ~clk;

   vpu_result_wb dut (
      .clk              (clk),
      .rst              (rst),
      .issue_valid_i    (issue_valid),
      .issue_dst_addr_i (issue_addr),
      .issue_ready_o    (issue_ready),
      .exec_done_i      (exec_done),
      .exec_dout_i      (exec_dout),
      .wr_valid_o       (wr_valid),
      .wr_ready_i       (wr_ready),
      .wr_addr_o        (wr_addr),
      .wr_data_o        (wr_data),
      .busy_o           (busy),
`ifdef VPU_WB_PARITY_EN
      .wr_parity_o      (wr_parity),
`endif
      .err_o            (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_model();
      logic [7:0]  ea;
      logic [31:0] ed;
      ea = (m_addr.size() > 0) ? m_addr[0] : 8'h00;
      ed = (m_data.size() > 0) ? m_data[0] : 32'h0;
      check("issue_ready", 64'(issue_ready), 64'(m_tag.size() < DEPTH));
      check("wr_valid", 64'(wr_valid), 64'(m_addr.size() > 0));
      check("wr_addr", 64'(wr_addr), 64'(ea));
      check("wr_data", 64'(wr_data), 64'(ed));
      check("busy", 64'(busy), 64'((m_tag.size() > 0) || (m_addr.size() > 0)));
      check("err", 64'(err), 64'(m_err));
`ifdef VPU_WB_PARITY_EN
      check("wr_parity", 64'(wr_parity), 64'(^ed));
`endif
   endtask

   // Applies the currently driven inputs as of the next rising edge.
   task automatic update_model();
      int  tag_n;
      bit  rise;
      logic [7:0] t;
      if (rst) begin
         m_tag.delete();
         m_addr.delete();
         m_data.delete();
         m_done_q = 1'b1;
         m_err    = 2'b00;
         return;
      end
      tag_n = m_tag.size();
      rise  = exec_done && !m_done_q;
      if (wr_ready && m_addr.size() > 0) begin
         void'(m_addr.pop_front());
         void'(m_data.pop_front());
      end
      if (rise) begin
         if (tag_n > 0) begin
            t = m_tag.pop_front();
            if (m_addr.size() < DEPTH) begin
               m_addr.push_back(t);
               m_data.push_back(exec_dout);
            end else begin
               m_err[0] = 1'b1;
            end
         end else begin
            m_err[1] = 1'b1;
         end
      end
      if (issue_valid && tag_n < DEPTH) m_tag.push_back(issue_addr);
      m_done_q = exec_done;
   endtask

   task automatic step(input logic r, input logic iv, input logic [7:0] a, input logic d,
                       input logic [31:0] dout, input logic rdy);
      @(posedge clk);
      #1;
      rst         = r;
      issue_valid = iv;
      issue_addr  = a;
      exec_done   = d;
      exec_dout   = dout;
      wr_ready    = rdy;
      @(negedge clk);
      compare_model();
      update_model();
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'h00, 1'b1, 32'h0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 1'b0);
   endtask

   task automatic issue(input logic [7:0] a, input logic rdy);
      step(1'b0, 1'b1, a, 1'b1, 32'h0, rdy);
   endtask

   task automatic complete(input logic [31:0] dout, input logic rdy);
      step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, rdy);
      step(1'b0, 1'b0, 8'h00, 1'b1, dout, rdy);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'h0, rdy);
   endtask

   initial begin
      do_reset();
      idle(1'b0);
      check("rst_issue_ready", 64'(issue_ready), 64'd1);
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      // Single op with a 3-cycle low done window
      issue(8'h12, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'hA5A5_A5A5, 1'b1);
      idle(1'b1);
      check("single_valid", 64'(wr_valid), 64'd1);
      check("single_addr", 64'(wr_addr), 64'h12);
      check("single_data", 64'(wr_data), 64'hA5A5_A5A5);
      idle(1'b1);
      check("single_busy", 64'(busy), 64'd0);

      // Back-pressure: three held, then drained in order
      issue(8'h31, 1'b0);
      issue(8'h32, 1'b0);
      issue(8'h33, 1'b0);
      complete(32'h1111_0001, 1'b0);
      complete(32'h1111_0002, 1'b0);
      complete(32'h1111_0003, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      check("bp_head_addr", 64'(wr_addr), 64'h31);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("bp_drained", 64'(busy), 64'd0);

      // Overflow: five completions into a 4-deep result FIFO
      do_reset();
      for (int i = 0; i < 4; i++) issue(8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 4; i++) complete(32'h2000_0000 + 32'(i), 1'b0);
      issue(8'h44, 1'b0);
      complete(32'h2000_0004, 1'b0);
      idle(1'b0);
      check("ovf_err", 64'(err), 64'd1);
      check("ovf_issue_ready", 64'(issue_ready), 64'd1);
      check("ovf_head", 64'(wr_addr), 64'h40);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Orphan done
      do_reset();
      complete(32'hDEAD_BEEF, 1'b1);
      idle(1'b1);
      check("orphan_err", 64'(err), 64'd2);
      check("orphan_no_write", 64'(wr_valid), 64'd0);

      // Tag queue full, then freed by one completion
      do_reset();
      for (int i = 0; i < 4; i++) issue(8'(8'h50 + i), 1'b1);
      idle(1'b1);
      check("tagfull_ready", 64'(issue_ready), 64'd0);
      complete(32'h3333_3333, 1'b1);
      idle(1'b1);
      check("tagfree_ready", 64'(issue_ready), 64'd1);
      for (int i = 0; i < 3; i++) complete(32'h3333_0000 + 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Reset with results pending
      issue(8'h61, 1'b0);
      issue(8'h62, 1'b0);
      complete(32'h0000_0001, 1'b0);
      complete(32'h0000_0002, 1'b0);
      idle(1'b0);
`ifdef VPU_WB_PARITY_EN
      check("parity_one", 64'(wr_parity), 64'd1);
`endif
      step(1'b1, 1'b0, 8'h00, 1'b1, 32'h0, 1'b0);
      idle(1'b1);
      check("rstmid_valid", 64'(wr_valid), 64'd0);
      check("rstmid_err", 64'(err), 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);

      // Random traffic, occasional reset
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 1)),
              8'($urandom),
              ($urandom_range(0, 2) != 0),
              $urandom,
              ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
